// File: rtl/pipe_defs_pkg.sv
// Shared pipeline definitions: register-number width and EX operand-mux select codes.
package pipe_defs;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/muldiv_busy_ctr.sv
// Mul/div occupancy timer: down-counter loaded on each start, busy while nonzero.
module muldiv_busy_ctr #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;

  // A new start reloads even when busy, so restart wins over the decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? DIV_LD : MULT_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX operand forwarding selects plus load-use / mul-div stall control.
// Optional stall-cycle performance counter built only with HAZARD_PERF_EN defined.
module hazard_fwd_ctrl
  import pipe_defs::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_hilo_rd,
  input  logic             id_md,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_md_start,
  input  logic             ex_md_div,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             bubble,
  output logic             md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  logic busy_raw;
  logic lu;
  logic mdh;
  logic hz;
  logic mem_a, mem_b, wb_a, wb_b;
  logic unused_regwrite;

  // Load-use only cares that EX is a load; its regwrite flag adds nothing here.
  assign unused_regwrite = ex_regwrite;

  muldiv_busy_ctr #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_busy_ctr (
    .clk   (clk),
    .rst   (rst),
    .start (ex_md_start),
    .div   (ex_md_div),
    .busy  (busy_raw)
  );

  always_comb begin
    md_busy = busy_raw & ~rst;

    lu  = ex_memread && (ex_rd != REG_ZERO) &&
          ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));
    mdh = (id_hilo_rd || id_md) && (md_busy || ex_md_start);
    hz  = (lu || mdh) && !rst;

    stall  = hz;
    bubble = hz;

    mem_a = mem_regwrite && (mem_rd != REG_ZERO) && (mem_rd == ex_rs);
    mem_b = mem_regwrite && (mem_rd != REG_ZERO) && (mem_rd == ex_rt);
    wb_a  = wb_regwrite  && (wb_rd  != REG_ZERO) && (wb_rd  == ex_rs);
    wb_b  = wb_regwrite  && (wb_rd  != REG_ZERO) && (wb_rd  == ex_rt);

    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (!rst) begin
      if (mem_a)     fwd_a_sel = FWD_MEM;
      else if (wb_a) fwd_a_sel = FWD_WB;
      if (mem_b)     fwd_b_sel = FWD_MEM;
      else if (wb_b) fwd_b_sel = FWD_WB;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (hz && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed pipeline scenarios plus random traffic vs a behavioural model.
module tb_hazard_fwd_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, id_hilo_rd, id_md;
  logic       ex_regwrite, ex_memread, ex_md_start, ex_md_div;
  logic       mem_regwrite, wb_regwrite;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, bubble, md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model: remaining busy cycles of the mul/div unit.
  int m_busy_left = 0;
`ifdef HAZARD_PERF_EN
  longint m_perf = 0;
`endif

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_hilo_rd   (id_hilo_rd),
    .id_md        (id_md),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_md_start  (ex_md_start),
    .ex_md_div    (ex_md_div),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .bubble       (bubble),
    .md_busy      (md_busy)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b01;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    logic reads_ld, lu, mdh;
    reads_ld = (id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd);
    lu  = ex_memread && ex_rd != 0 && reads_ld;
    mdh = (id_hilo_rd || id_md) && (m_busy_left > 0 || ex_md_start);
    return !rst && (lu || mdh);
  endfunction

  always @(posedge clk) begin
    if (rst) m_busy_left <= 0;
    else if (ex_md_start) m_busy_left <= ex_md_div ? DIV_N : MULT_N;
    else if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
`ifdef HAZARD_PERF_EN
    if (rst) m_perf <= 0;
    else if (m_stall() && m_perf < 64'hFFFF_FFFF) m_perf <= m_perf + 1;
`endif
  end

  // Every cycle: all outputs against the model, mid-cycle away from the edge.
  always @(negedge clk) begin
    logic [1:0] ea, eb;
    logic       es;
    ea = rst ? 2'b00 : m_fwd(ex_rs);
    eb = rst ? 2'b00 : m_fwd(ex_rt);
    es = m_stall();
    chk("model_fwd_a", {30'd0, fwd_a_sel}, {30'd0, ea});
    chk("model_fwd_b", {30'd0, fwd_b_sel}, {30'd0, eb});
    chk("model_stall", {31'd0, stall}, {31'd0, es});
    chk("model_bubble", {31'd0, bubble}, {31'd0, es});
    chk("model_md_busy", {31'd0, md_busy}, {31'd0, !rst && m_busy_left > 0});
`ifdef HAZARD_PERF_EN
    chk("model_perf", perf_stall_cnt, m_perf[31:0]);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs, id_use_rt, id_hilo_rd, id_md} = '0;
    {ex_regwrite, ex_memread, ex_md_start, ex_md_div} = '0;
    {mem_regwrite, wb_regwrite} = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] rreg();
    logic [4:0] pick [4];
    pick[0] = 5'd0; pick[1] = 5'd8; pick[2] = 5'd9; pick[3] = 5'd10;
    if ($urandom_range(0, 4) == 0) return 5'($urandom_range(0, 31));
    return pick[$urandom_range(0, 3)];
  endfunction

  initial begin
    int st, bz, rel;
    rst = 1'b1;
    idle();
    tick();
    samp();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    do_reset();

    // Forwarding priority and $0 suppression.
    ex_rs = 5'd8; ex_rt = 5'd8;
    mem_rd = 5'd8; mem_regwrite = 1'b1; wb_rd = 5'd8; wb_regwrite = 1'b1;
    samp();
    chk("fwd_a_mem_prio", {30'd0, fwd_a_sel}, 32'd1);
    chk("fwd_b_mem_prio", {30'd0, fwd_b_sel}, 32'd1);
    tick();
    mem_regwrite = 1'b0;
    samp();
    chk("fwd_a_wb", {30'd0, fwd_a_sel}, 32'd2);
    tick();
    ex_rs = 5'd0; ex_rt = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    samp();
    chk("fwd_a_zero", {30'd0, fwd_a_sel}, 32'd0);
    chk("fwd_b_zero", {30'd0, fwd_b_sel}, 32'd0);

    // Load-use: one stall, then the consumer picks up the load from WB.
    tick();
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9;
    id_use_rt = 1'b1; id_rt = 5'd9;
    samp();
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_bubble", {31'd0, bubble}, 32'd1);
    tick();
    idle();
    id_use_rt = 1'b1; id_rt = 5'd9;
    mem_rd = 5'd9; mem_regwrite = 1'b1;
    samp();
    chk("lu_release", {31'd0, stall}, 32'd0);
    tick();
    idle();
    ex_rt = 5'd9; wb_rd = 5'd9; wb_regwrite = 1'b1;
    samp();
    chk("lu_fwd_b_wb", {30'd0, fwd_b_sel}, 32'd2);

    // MULT with MFHI directly behind it.
    do_reset();
    ex_md_start = 1'b1; id_hilo_rd = 1'b1;
    st = 0; bz = 0; rel = -1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin tick(); ex_md_start = 1'b0; end
      samp();
      st += int'(stall);
      bz += int'(md_busy);
      if (!stall && rel < 0) rel = k;
    end
    chk("mult_stall_cycles", st, 32'd5);
    chk("mult_busy_cycles", bz, 32'd4);
    chk("mult_release_idx", rel, 32'd5);

    // DIV with MULT waiting in ID.
    do_reset();
    ex_md_start = 1'b1; ex_md_div = 1'b1; id_md = 1'b1;
    st = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin tick(); ex_md_start = 1'b0; end
      samp();
      st += int'(stall);
    end
    chk("div_stall_cycles", st, 32'd33);

    // Reset during a divide abandons the busy count.
    do_reset();
    ex_md_start = 1'b1; ex_md_div = 1'b1; id_md = 1'b1;
    samp();
    for (int k = 1; k <= 10; k++) begin
      tick();
      ex_md_start = 1'b0;
      if (k == 10) rst = 1'b1;
      samp();
    end
    chk("rst_forces_stall0", {31'd0, stall}, 32'd0);
    chk("rst_forces_busy0", {31'd0, md_busy}, 32'd0);
    tick();
    rst = 1'b0;
    samp();
    chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);

    // Load-use overlapping a multiply hazard; load-use held past mdh.
    do_reset();
    ex_md_start = 1'b1; id_md = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd10; id_use_rs = 1'b1; id_rs = 5'd10;
    st = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin tick(); ex_md_start = 1'b0; end
      if (k == 7) ex_memread = 1'b0;
      samp();
      st += int'(stall);
      if (k < 7) chk("overlap_stall", {31'd0, stall}, 32'd1);
    end
    chk("overlap_total", st, 32'd7);

`ifdef HAZARD_PERF_EN
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd8; id_use_rs = 1'b1; id_rs = 5'd8;
    for (int k = 0; k < 7; k++) tick();
    idle();
    samp();
    chk("perf_seven", perf_stall_cnt, 32'd7);
`endif

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      id_rs = rreg(); id_rt = rreg(); ex_rs = rreg(); ex_rt = rreg();
      ex_rd = rreg(); mem_rd = rreg(); wb_rd = rreg();
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      id_hilo_rd = ($urandom_range(0, 3) == 0);
      id_md = ($urandom_range(0, 3) == 0);
      ex_regwrite = 1'($urandom); ex_memread = ($urandom_range(0, 2) == 0);
      ex_md_start = ($urandom_range(0, 11) == 0);
      ex_md_div = ($urandom_range(0, 3) == 0);
      mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
      tick();
    end

    idle();
    rst = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
